// File: rtl/mcp3202_conv_scheduler.sv
// MCP3202 conversion scheduler: tick divider, round-robin channel select, AXIS sample output; conv_start 1 cycle after tick, tvalid 1 cycle after conv_done.
// AXIS backpressure holds the sample; ticks during CONV/XFER are dropped (counted in overrun_cnt when SCHED_OVERRUN_CNT_EN is defined).
module mcp3202_conv_scheduler #(
    parameter int unsigned FCLK    = 100_000_000,
    parameter int unsigned FSMPL   = 500,
    parameter int unsigned PKT_LEN = 64,
    parameter logic [1:0]  CH_MASK = 2'b01,
    parameter logic        SGL     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        conv_start,
    output logic        conv_sgl,
    output logic        conv_odd,
    input  logic        conv_done,
    input  logic [11:0] conv_data,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tlast
`ifdef SCHED_OVERRUN_CNT_EN
    ,
    output logic [15:0] overrun_cnt
`endif
);

    localparam int unsigned DIV = FCLK / FSMPL;
    localparam int          DW  = $clog2(DIV);
    localparam int          PW  = $clog2(PKT_LEN);

    localparam logic [1:0]    MASK     = (CH_MASK == 2'b00) ? 2'b01 : CH_MASK;
    localparam logic          FIRST_CH = ~MASK[0];
    localparam logic          BOTH_CH  = &MASK;
    localparam logic [DW-1:0] DIV_TC   = DW'(DIV - 1);
    localparam logic [PW-1:0] PKT_LAST = PW'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CONV, XFER} state_t;

    state_t        state, next_state;
    logic [DW-1:0] div_cnt;
    logic [PW-1:0] pkt_cnt;
    logic          ch;
    logic          tick;
    logic          start_conv;
    logic          hs;

    assign tick          = en && (div_cnt == DIV_TC);
    assign m_axis_tvalid = (state == XFER);
    assign hs            = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid && (pkt_cnt == PKT_LAST);
    assign conv_odd      = ch;
    assign conv_sgl      = SGL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_conv = 1'b0;
        case (state)
            IDLE: if (en) next_state = WAIT;
            WAIT: begin
                if (!en) begin
                    next_state = IDLE;
                end else if (tick) begin
                    next_state = CONV;
                    start_conv = 1'b1;
                end
            end
            CONV: if (conv_done) next_state = XFER;
            XFER: if (hs) next_state = en ? WAIT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_start   <= 1'b0;
            m_axis_tdata <= '0;
        end else begin
            conv_start <= start_conv;
            if (state == CONV && conv_done) begin
                m_axis_tdata <= {3'b000, ch, conv_data};
            end
        end
    end

    // Leaving for IDLE restarts the packet and the channel rotation, so a cut-short packet carries no tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch      <= 1'b0;
            pkt_cnt <= '0;
        end else if (next_state == IDLE) begin
            ch      <= FIRST_CH;
            pkt_cnt <= '0;
        end else if (hs) begin
            ch      <= BOTH_CH ? ~ch : FIRST_CH;
            pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
        end
    end

`ifdef SCHED_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= '0;
        end else if (tick && (state == CONV || state == XFER) && overrun_cnt != 16'hFFFF) begin
            overrun_cnt <= overrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mcp3202_conv_scheduler.sv
// Bench for mcp3202_conv_scheduler: 100-cycle sample grid, two channels, 4-sample packets, SPI engine model with 40-cycle latency.
module tb_mcp3202_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        conv_start, conv_sgl, conv_odd;
    logic        conv_done = 1'b0;
    logic [11:0] conv_data = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;
`ifdef SCHED_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt;
`endif

    mcp3202_conv_scheduler #(
        .FCLK(1_000_000), .FSMPL(10_000), .PKT_LEN(4), .CH_MASK(2'b11), .SGL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .conv_start(conv_start), .conv_sgl(conv_sgl), .conv_odd(conv_odd),
        .conv_done(conv_done), .conv_data(conv_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
`ifdef SCHED_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI engine model: answers 40 cycles after conv_start with 12'h100 + conversion index.
    int spi_cd = 0;
    int spi_n  = 0;
    always @(negedge clk) begin
        conv_done = 1'b0;
        if (spi_cd > 0) begin
            spi_cd = spi_cd - 1;
            if (spi_cd == 0) begin
                conv_done = 1'b1;
                conv_data = 12'(32'h100 + spi_n);
                spi_n = spi_n + 1;
            end
        end
        if (conv_start) spi_cd = 40;
    end

    int   vectors = 0;
    int   miscompares = 0;
    logic exp_ch = 1'b0;
    int   exp_idx = 0;
    int   exp_pcnt = 0;
    int   next_grid = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!conv_start && n < budget) begin step(); n++; end
        if (!conv_start) check("start_timeout", 32'(conv_start), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!m_axis_tvalid && n < budget) begin step(); n++; end
        if (!m_axis_tvalid) check("valid_timeout", 32'(m_axis_tvalid), 32'd1);
    endtask

    // One conversion: checks grid timing, channel, stalled hold and the handshake beat.
    task automatic do_sample(input int stall, input int drop_en_after);
        logic [15:0] exp_dat;
        logic        exp_last;
        wait_start(400);
        check("start_grid", 32'(cyc), 32'(next_grid));
        check("conv_odd", 32'(conv_odd), 32'(exp_ch));
        check("conv_sgl", 32'(conv_sgl), 32'd1);
        next_grid = next_grid + 100;
        if (drop_en_after > 0) begin
            repeat (drop_en_after) step();
            en = 1'b0;
        end
        wait_valid(100);
        exp_dat  = {3'b000, exp_ch, 12'(32'h100 + exp_idx)};
        exp_last = (exp_pcnt == 3);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 32'(m_axis_tvalid), 32'd1);
            check("stall_tdata", 32'(m_axis_tdata), 32'(exp_dat));
            check("stall_tlast", 32'(m_axis_tlast), 32'(exp_last));
            step();
        end
        m_axis_tready = 1'b1;
        check("tdata", 32'(m_axis_tdata), 32'(exp_dat));
        check("tlast", 32'(m_axis_tlast), 32'(exp_last));
        step();
        m_axis_tready = 1'b0;
        check("valid_fall", 32'(m_axis_tvalid), 32'd0);
        exp_idx++;
        exp_ch   = ~exp_ch;
        exp_pcnt = (exp_pcnt + 1) % 4;
    endtask

    task automatic enable_now();
        en = 1'b1;
        next_grid = cyc + 100;
    endtask

    initial begin
        int seen;
        repeat (3) step();
        check("rst_conv_start", 32'(conv_start), 32'd0);
        check("rst_conv_odd", 32'(conv_odd), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_conv_sgl", 32'(conv_sgl), 32'd1);
`ifdef SCHED_OVERRUN_CNT_EN
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (5) step();
        check("idle_no_start", 32'(conv_start), 32'd0);

        enable_now();
        for (int k = 0; k < 6; k++) do_sample(k == 0 ? 0 : $urandom_range(0, 30), 0);
        do_sample(30, 0);
`ifdef SCHED_OVERRUN_CNT_EN
        check("overrun_none", 32'(overrun_cnt), 32'd0);
`endif

        do_sample(150, 0);
        next_grid = next_grid + 100;
`ifdef SCHED_OVERRUN_CNT_EN
        check("overrun_one", 32'(overrun_cnt), 32'd1);
`endif
        do_sample($urandom_range(0, 30), 0);

        do_sample($urandom_range(0, 20), 10);
        exp_ch = 1'b0;
        exp_pcnt = 0;
        seen = 0;
        repeat (300) begin
            step();
            if (conv_start) seen++;
        end
        check("disabled_no_start", 32'(seen), 32'd0);
        enable_now();
        for (int k = 0; k < 4; k++) do_sample($urandom_range(0, 30), 0);

        wait_start(400);
        check("pre_rst_grid", 32'(cyc), 32'(next_grid));
        wait_valid(100);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("async_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("async_tdata", 32'(m_axis_tdata), 32'd0);
        check("async_conv_odd", 32'(conv_odd), 32'd0);
        check("async_tlast", 32'(m_axis_tlast), 32'd0);
`ifdef SCHED_OVERRUN_CNT_EN
        check("async_overrun", 32'(overrun_cnt), 32'd0);
`endif
        repeat (3) step();
        rst_n = 1'b1;
        step();
        exp_idx++;
        exp_ch = 1'b0;
        exp_pcnt = 0;
        enable_now();
        for (int k = 0; k < 5; k++) do_sample($urandom_range(0, 30), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcp3202_conv_scheduler.md
# mcp3202_conv_scheduler

Conversion scheduler for the MCP3202 SPI front end. It generates the sample-rate trigger and selects the ADC channel for each conversion, round-robin across the enabled channels. It starts each conversion on the SPI engine and returns the 12-bit result as an AXI4-Stream sample tagged with its channel. `tlast` marks every `PKT_LEN`-th sample so the downstream subset converter and DMA receive fixed-size packets.

## Interface
- `FCLK`, 100e6, system clock frequency in Hz.
- `FSMPL`, 500, aggregate conversion rate in Hz, one conversion per tick. `FCLK/FSMPL` must be ≥ 64.
- `PKT_LEN`, 64, samples per AXIS packet, range 2..65535.
- `CH_MASK`, 2'b01, enabled channels, bit0 = CH0 and bit1 = CH1. The value 2'b00 is treated as 2'b01.
- `SGL`, 1, value driven on `conv_sgl`: 1 = single-ended, 0 = pseudo-differential.

Ports:
- `clk` in 1: system clock. Everything is in the rising-edge domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable, level-sensitive.
- `conv_start` out 1: one-cycle pulse that requests a conversion from the SPI engine.
- `conv_sgl` out 1: mode bit for the SPI engine, equal to `SGL`.
- `conv_odd` out 1: channel select, stable from `conv_start` until `conv_done`.
- `conv_done` in 1: one-cycle pulse from the SPI engine; `conv_data` is valid in the same cycle.
- `conv_data` in 12: conversion result.
- `m_axis_tvalid` out 1: AXIS valid.
- `m_axis_tready` in 1: AXIS ready.
- `m_axis_tdata` out 16: `{3'b000, ch, data[11:0]}`.
- `m_axis_tlast` out 1: last sample of a packet.
- `overrun_cnt` out 16: dropped-tick count. Present only with `SCHED_OVERRUN_CNT_EN`.

## Operation
- Tick divider:
  - Counts from 0 to `FCLK/FSMPL-1` (integer division) and pulses `tick` for one cycle at terminal count.
  - Runs only while `en` = 1. It is cleared to 0 whenever `en` = 0.
- States:
  - IDLE → WAIT when `en` = 1.
  - WAIT → CONV on `tick`. `conv_start` is pulsed in the transition cycle.
  - CONV → XFER on `conv_done`. The sample is registered.
  - XFER → WAIT on `m_axis_tvalid && m_axis_tready`, when `en` = 1.
  - XFER → IDLE on `m_axis_tvalid && m_axis_tready`, when `en` = 0.
  - WAIT → IDLE when `en` = 0.
- CONV and XFER always complete, even if `en` falls, so no half-finished SPI frame is ever abandoned.
- Channel sequencing:
  - Channel pointer `ch` advances after each accepted transfer to the next enabled channel.
  - With `CH_MASK` = 2'b11 the sequence is 0, 1, 0, 1, …
  - With a single enabled channel, `ch` is constant.
  - `conv_odd` equals `ch`.
- Packet counter:
  - Counts 0..`PKT_LEN-1`, increments on each handshake and wraps to 0 after the last sample.
  - `m_axis_tlast` = (counter == `PKT_LEN-1`) while `m_axis_tvalid` is high.
- Overrun: a `tick` while in CONV or XFER is dropped and no conversion is queued. With the macro, `overrun_cnt` increments and saturates at 16'hFFFF.
- Return to IDLE: the packet counter and channel pointer reset to 0 (first enabled channel). A truncated packet therefore ends without `tlast`.
- `conv_done` outside CONV is ignored.

## Timing
- Reset values:
  - All outputs are 0 (`conv_start`, `conv_odd`, `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`, `overrun_cnt`).
  - `conv_sgl` = `SGL`.
  - State is IDLE; divider, packet counter and channel pointer are 0.
- First tick comes `FCLK/FSMPL` cycles after the first cycle with `en` = 1.
- `conv_start` is registered and high for exactly 1 cycle, starting the cycle after the divider reaches terminal count.
- `m_axis_tvalid` rises 1 cycle after `conv_done` is sampled high.
- While `tvalid && !tready`: `tdata`, `tlast` and `tvalid` are held stable.
- `tvalid` falls in the cycle after the handshake.
- Reset mid-operation: immediate return to the reset values. The SPI engine is reset by the same `rst_n`.

## Configuration
- `SCHED_OVERRUN_CNT_EN`:
  - Defined: the `overrun_cnt` port and its saturating counter exist. The counter is cleared only by `rst_n`.
  - Undefined: both the port and the logic are omitted, and dropped ticks are silent. Scheduling behaviour is otherwise identical.

## Test plan
Parameters for all scenarios: `FCLK`=1e6, `FSMPL`=1e4 (100-cycle period). The bench SPI model answers `conv_done` 40 cycles after `conv_start`, with data = 12'h100 + conversion index.

- **Single channel, tready = 1.** `CH_MASK`=01, `PKT_LEN`=4, `en`=1 → `conv_start` every 100 cycles with `conv_odd`=0. `tdata` = 16'h0100, 16'h0101, … and `tlast` is on every 4th sample.
- **Alternating channels.** `CH_MASK`=11 → `conv_odd` sequence 0,1,0,1. `tdata` bit12 matches the channel, e.g. the second sample is 16'h1101.
- **Backpressure within period.** Hold `tready`=0 for 30 cycles after `tvalid` → `tdata`/`tlast` are stable, there is no overrun, and the next `conv_start` stays on the 100-cycle grid.
- **Backpressure overrun.** Hold `tready`=0 for 150 cycles → exactly one tick is dropped and `overrun_cnt`=1 (macro on). The next `conv_start` comes on the following tick.
- **Disable mid-conversion.** Drop `en` 10 cycles after `conv_start` → the conversion and transfer complete, then the block enters IDLE with no further `conv_start`. On re-enable, the first sample is CH0 and the packet counter is 0.
- **Async reset during XFER.** Assert `rst_n`=0 while `tvalid`=1 → `tvalid` goes to 0 immediately without waiting for a clock edge. All counters are 0 after release.
